// File: rtl/wdt_pkg.sv
// rtl/wdt_pkg.sv - shared state encoding and decode helpers for the watchdog supervisor
package wdt_pkg;

   localparam int WDT_STATE_W = 2;

   typedef enum logic [WDT_STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WARN = 2'd2,
      ST_BITE = 2'd3
   } wdt_state_e;

   // Anything past IDLE freezes configuration until reset.
   function automatic logic is_locked(input wdt_state_e s);
      return s != ST_IDLE;
   endfunction

   function automatic logic is_counting(input wdt_state_e s);
      return (s == ST_RUN) || (s == ST_WARN);
   endfunction

endpackage

// File: rtl/wdt_counter.sv
// rtl/wdt_counter.sv - watchdog up-counter with clear, increment enable and freeze
module wdt_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_clr,
   input  logic          i_inc,
   input  logic          i_freeze,
   output logic [CW-1:0] o_count
);

   logic [CW-1:0] r_count;

   // Clear dominates freeze so a fresh run always starts from zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !i_freeze) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/wdt_supervisor.sv
// rtl/wdt_supervisor.sv - windowed watchdog: config lock, kick window, warn and bite escalation
module wdt_supervisor
   import wdt_pkg::*;
#(
   parameter int CW    = 16,
   parameter int GRACE = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CW-1:0]          cfg_timeout,
   input  logic [CW-1:0]          cfg_window,
   input  logic                   enable,
   input  logic                   kick,
   input  logic                   irq_ack,
   output logic                   irq_warn,
   output logic                   rst_req,
   output logic [WDT_STATE_W-1:0] state,
   output logic [CW-1:0]          count
);

   localparam logic [CW-1:0] GRACE_LAST = CW'(GRACE - 1);

   wdt_state_e    r_state;
   logic [CW-1:0] r_timeout;
   logic [CW-1:0] r_window;
   logic          r_cfg_ready;
   logic          r_irq_warn;
   logic          r_rst_req;

   logic [CW-1:0] w_count;
   logic [CW-1:0] w_new_timeout;
   logic [CW-1:0] w_new_window;
   logic          w_cfg_take;
   logic          w_in_run;
   logic          w_in_warn;
   logic          w_early;
   logic          w_run_viol;
   logic          w_run_kick;
   logic          w_run_expire;
   logic          w_warn_kick;
   logic          w_warn_expire;
   logic          w_clr;
   logic          w_inc;
   logic          w_freeze;

   // Zero timeout is promoted to 1; a window not shorter than the timeout disables windowing.
   assign w_cfg_take    = !is_locked(r_state) && cfg_valid;
   assign w_new_timeout = (cfg_timeout == '0) ? CW'(1) : cfg_timeout;
   assign w_new_window  = (cfg_window >= w_new_timeout) ? '0 : cfg_window;

   assign w_in_run      = (r_state == ST_RUN);
   assign w_in_warn     = (r_state == ST_WARN);
   assign w_early       = (w_count < r_window);
   assign w_run_viol    = w_in_run && kick && w_early;
   assign w_run_kick    = w_in_run && kick && !w_early;
   assign w_run_expire  = w_in_run && !kick && (w_count == r_timeout - CW'(1));
   assign w_warn_kick   = w_in_warn && kick;
   assign w_warn_expire = w_in_warn && !kick && (w_count == GRACE_LAST);

   // Counter decisions are made from the current state so count moves on the same edge as the FSM.
   assign w_clr    = !is_locked(r_state) || w_run_kick || w_run_expire || w_warn_kick;
   assign w_freeze = (r_state == ST_BITE) || w_run_viol || w_warn_expire;
   assign w_inc    = is_counting(r_state);

   wdt_counter #(
      .CW(CW)
   ) u_counter (
      .clk      (clk),
      .rstn     (rstn),
      .i_clr    (w_clr),
      .i_inc    (w_inc),
      .i_freeze (w_freeze),
      .o_count  (w_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_timeout   <= '1;
         r_window    <= '0;
         r_cfg_ready <= 1'b1;
         r_irq_warn  <= 1'b0;
         r_rst_req   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cfg_take) begin
                  r_timeout <= w_new_timeout;
                  r_window  <= w_new_window;
               end
               if (enable) begin
                  r_state     <= ST_RUN;
                  r_cfg_ready <= 1'b0;
               end
            end
            ST_RUN: begin
               if (w_run_viol) begin
                  r_state   <= ST_BITE;
                  r_rst_req <= 1'b1;
               end else if (w_run_expire) begin
                  r_state    <= ST_WARN;
                  r_irq_warn <= 1'b1;
               end
            end
            ST_WARN: begin
               if (w_warn_kick) begin
                  r_state    <= ST_RUN;
                  r_irq_warn <= 1'b0;
               end else begin
                  if (irq_ack) begin
                     r_irq_warn <= 1'b0;
                  end
                  if (w_warn_expire) begin
                     r_state   <= ST_BITE;
                     r_rst_req <= 1'b1;
                  end
               end
            end
            ST_BITE: begin
               r_rst_req <= 1'b1;
            end
         endcase
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign irq_warn  = r_irq_warn;
   assign rst_req   = r_rst_req;
   assign state     = r_state;
   assign count     = w_count;

endmodule

// File: doc/wdt_supervisor.md
# wdt_supervisor

Windowed watchdog supervisor that configures, sequences and escalates a single watchdog counter. Software loads timeout/window through a valid/ready config port, then enables the watchdog. From then on the block enforces windowed kicks, raises a warning interrupt on first expiry and requests a system reset if the warning is not serviced within a grace period. It sits between the CPU register interface and the system reset controller.

## Interface
- CW, 16, counter and configuration width in bits
- GRACE, 8, cycles allowed in WARN before escalation to BITE (≥1)

- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- cfg_valid  input  1  configuration offered
- cfg_ready  output  1  configuration accepted this cycle when high with cfg_valid
- cfg_timeout  input  CW  cycles from kick/enable to expiry
- cfg_window  input  CW  closed-window length; kicks while count < window are violations
- enable  input  1  start request, sampled only in IDLE
- kick  input  1  single-cycle service pulse (level treated as one kick per cycle)
- irq_ack  input  1  clears irq_warn without servicing the watchdog
- irq_warn  output  1  warning interrupt, level
- rst_req  output  1  system reset request, sticky until rstn
- state  output  2  current state encoding
- count  output  CW  current counter value

## Operation
- States: IDLE=0, RUN=1, WARN=2, BITE=3.
- IDLE: cfg_ready=1; cfg_valid latches timeout/window. cfg_timeout=0 stored as 1. cfg_window ≥ stored timeout stored as 0 (window disabled). enable=1 → RUN, count←0. Config and enable in same cycle: new config used.
- Lock: once out of IDLE, cfg_ready=0, cfg_valid and enable ignored; only rstn returns to IDLE.
- RUN: count increments each cycle. kick with count < window → BITE. kick with count ≥ window → count←0. No kick and count == timeout−1 → WARN, count←0, irq_warn←1. Kick and expiry same cycle: kick wins (count ≥ window always holds there).
- WARN: count increments. kick (window not applied) → RUN, count←0, irq_warn←0. irq_ack → irq_warn←0, stay WARN. kick and irq_ack together: kick behaviour. No kick and count == GRACE−1 → BITE.
- BITE: rst_req=1, irq_warn holds last value, count frozen; terminal until rstn.
- Counter never wraps: terminal compares occur before CW overflow because timeout ≤ 2^CW−1.

## Timing
- Reset values: state=IDLE, cfg_ready=1, irq_warn=0, rst_req=0, count=0, stored timeout=2^CW−1, window=0.
- All outputs registered; state transitions visible the cycle after the deciding edge.
- Enable sampled at edge E0; with no kicks irq_warn rises after edge E_timeout, rst_req after edge E_(timeout+GRACE).
- Early-kick violation: rst_req high one cycle after the kick is sampled.
- Kick in RUN: count reads 0 the next cycle, 1 the cycle after.
- rstn assertion mid-operation: immediate return to reset values, no glitch on rst_req deassert beyond rstn release.

## Structure
- Package wdt_pkg: state enum wdt_state_e (2-bit, encodings above), shared state-decode constants.
- Sub-module wdt_counter: CW-bit up-counter with synchronous clear, increment enable and freeze; supervisor FSM drives clear/enable.
- Supervisor FSM, config registers and output registers in wdt_supervisor; target 150–250 lines total.

## Test plan
(CW=8, GRACE=8, timeout=16, window=4 unless stated)
- Periodic kick at count 10 for 200 cycles → irq_warn=0, rst_req=0, state stays RUN.
- No kick after enable → irq_warn rises 16 cycles after enable edge, rst_req 8 cycles later, held until rstn.
- Kick at count 2 → state=BITE, rst_req=1 next cycle.
- Reach WARN, pulse irq_ack → irq_warn=0, state=WARN; then kick at WARN count 3 → state=RUN, count=0, rst_req stays 0.
- cfg_window=20, cfg_timeout=16 → window stored 0, kick at count 0 accepted; cfg_valid in RUN → cfg_ready=0, config unchanged; cfg_timeout=0 → irq_warn after 1 cycle.
- rstn pulse while in WARN and while in BITE → state=IDLE, irq_warn=0, rst_req=0, count=0, cfg_ready=1.
